// File: rtl/arty_io_conditioner_if.sv
// Pin-side bundle between the Arty S7 board pins and the I/O conditioner.
// The board/bench side uses master; the conditioner uses slave.
interface arty_io_conditioner_if #(
    parameter int NUM_LEDS = 4
);
    logic                btn_n_raw;
    logic                rxd_raw;
    logic                core_txd;
    logic [NUM_LEDS-1:0] core_status;
    logic                led_mode;
    logic                rxd_sync;
    logic                txd;
    logic                core_reset;
    logic [NUM_LEDS-1:0] led;

    modport master (
        output btn_n_raw, rxd_raw, core_txd, core_status, led_mode,
        input  rxd_sync, txd, core_reset, led
    );

    modport slave (
        input  btn_n_raw, rxd_raw, core_txd, core_status, led_mode,
        output rxd_sync, txd, core_reset, led
    );
endinterface

// File: rtl/arty_io_conditioner.sv
// Board-level I/O conditioning for top_md5: pin synchronisers, button debounce,
// stretched core reset, registered TX and a mode-selectable LED bank.
module arty_io_conditioner #(
    parameter int CLK_FREQUENCY      = 100_000_000,
    parameter int HEARTBEAT_HZ       = 1,
    parameter int NUM_LEDS           = 4,
    parameter int SYNC_STAGES        = 2,
    parameter int DEBOUNCE_CYCLES    = 1_000_000,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int ACT_STRETCH_CYCLES = 5_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    arty_io_conditioner_if.slave  io
);
    localparam int HB_HALF = CLK_FREQUENCY / (2 * HEARTBEAT_HZ);
    localparam int HB_W    = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;
    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W  = $clog2(RST_HOLD_CYCLES + 1);
    localparam int ACT_W   = $clog2(ACT_STRETCH_CYCLES + 1);

    localparam logic [HB_W-1:0]   HB_LAST = HB_W'(HB_HALF - 1);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(RST_HOLD_CYCLES);
    localparam logic [ACT_W-1:0]  ACT_LD  = ACT_W'(ACT_STRETCH_CYCLES);

    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   pressed;
    logic                   btn_db;
    logic [DB_W-1:0]        db_cnt;
    logic [HOLD_W-1:0]      hold_cnt;
    logic                   core_rst_q;
    logic                   txd_q;
    logic                   rx_prev;
    logic                   tx_prev;
    logic                   rx_fall;
    logic                   tx_fall;
    logic [ACT_W-1:0]       rx_cnt;
    logic [ACT_W-1:0]       tx_cnt;
    logic [HB_W-1:0]        hb_cnt;
    logic                   hb;
    logic [NUM_LEDS-1:0]    diag;
    logic [NUM_LEDS-1:0]    led_q;

    // Idle-high reset of every stage keeps the released pins from looking like edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_sync <= '1;
            rx_sync  <= '1;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], io.btn_n_raw};
            rx_sync  <= {rx_sync[SYNC_STAGES-2:0], io.rxd_raw};
        end
    end

    assign pressed = ~btn_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (pressed == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_db <= pressed;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_cnt   <= HOLD_LD;
            core_rst_q <= 1'b1;
            txd_q      <= 1'b1;
        end else begin
            if (btn_db)
                hold_cnt <= HOLD_LD;
            else if (hold_cnt != '0)
                hold_cnt <= hold_cnt - HOLD_W'(1);
            core_rst_q <= (hold_cnt != '0);
            txd_q      <= io.core_txd;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync[SYNC_STAGES-1];
    assign tx_fall = tx_prev & ~txd_q;

    // Stretchers and heartbeat ignore core_reset so the LEDs stay live during a hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_prev <= 1'b1;
            tx_prev <= 1'b1;
            rx_cnt  <= '0;
            tx_cnt  <= '0;
            hb_cnt  <= '0;
            hb      <= 1'b0;
        end else begin
            rx_prev <= rx_sync[SYNC_STAGES-1];
            tx_prev <= txd_q;
            if (rx_fall)
                rx_cnt <= ACT_LD;
            else if (rx_cnt != '0)
                rx_cnt <= rx_cnt - ACT_W'(1);
            if (tx_fall)
                tx_cnt <= ACT_LD;
            else if (tx_cnt != '0)
                tx_cnt <= tx_cnt - ACT_W'(1);
            if (hb_cnt == HB_LAST) begin
                hb_cnt <= '0;
                hb     <= ~hb;
            end else begin
                hb_cnt <= hb_cnt + HB_W'(1);
            end
        end
    end

    always_comb begin
        diag    = io.core_status;
        diag[0] = hb;
        diag[1] = (rx_cnt != '0);
        diag[2] = (tx_cnt != '0);
    end

    always_ff @(posedge clk) begin
        if (reset)
            led_q <= '0;
        else
            led_q <= io.led_mode ? io.core_status : diag;
    end

    assign io.rxd_sync   = rx_sync[SYNC_STAGES-1];
    assign io.txd        = txd_q;
    assign io.core_reset = core_rst_q;
    assign io.led        = led_q;
endmodule

// File: tb/tb_arty_io_conditioner.sv
// Directed bench for arty_io_conditioner with small timing parameters and
// hand-computed cycle-by-cycle expectations.
module tb_arty_io_conditioner;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    arty_io_conditioner_if #(.NUM_LEDS(4)) io ();

    arty_io_conditioner #(
        .CLK_FREQUENCY     (20),
        .HEARTBEAT_HZ      (1),
        .NUM_LEDS          (4),
        .SYNC_STAGES       (2),
        .DEBOUNCE_CYCLES   (4),
        .RST_HOLD_CYCLES   (3),
        .ACT_STRETCH_CYCLES(5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        io.btn_n_raw   = 1'b1;
        io.rxd_raw     = 1'b1;
        io.core_txd    = 1'b1;
        io.core_status = 4'b0000;
        io.led_mode    = 1'b0;

        // reset and heartbeat
        tick();
        tick();
        check("rst_led", 32'(io.led), 32'h0);
        check("rst_txd", 32'(io.txd), 32'h1);
        check("rst_core_reset", 32'(io.core_reset), 32'h1);
        check("rst_rxd_sync", 32'(io.rxd_sync), 32'h1);
        reset = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            tick();
            if (e == 3)  check("rel_hold_e3", 32'(io.core_reset), 32'h1);
            if (e == 4)  check("rel_fall_e4", 32'(io.core_reset), 32'h0);
            if (e == 10) check("hb_e10", 32'(io.led[0]), 32'h0);
            if (e == 11) check("hb_e11", 32'(io.led[0]), 32'h1);
            if (e == 20) check("hb_e20", 32'(io.led[0]), 32'h1);
            if (e == 21) check("hb_e21", 32'(io.led[0]), 32'h0);
        end

        // 3-sample glitch must not pass the debouncer
        io.btn_n_raw = 1'b0;
        repeat (3) tick();
        io.btn_n_raw = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 5 || e == 10)
                check("glitch_core_reset", 32'(io.core_reset), 32'h0);
        end

        // valid press: 10 low samples
        for (int e = 1; e <= 20; e++) begin
            io.btn_n_raw = (e <= 10) ? 1'b0 : 1'b1;
            tick();
            if (e == 7)  check("press_e7", 32'(io.core_reset), 32'h0);
            if (e == 8)  check("press_e8", 32'(io.core_reset), 32'h1);
            if (e == 19) check("unpress_e19", 32'(io.core_reset), 32'h1);
            if (e == 20) check("unpress_e20", 32'(io.core_reset), 32'h0);
        end

        // single RX low pulse
        for (int e = 1; e <= 10; e++) begin
            io.rxd_raw = (e == 1) ? 1'b0 : 1'b1;
            tick();
            if (e == 1) check("rxs_e1", 32'(io.rxd_sync), 32'h1);
            if (e == 2) check("rxs_e2", 32'(io.rxd_sync), 32'h0);
            if (e == 3) check("rxs_e3", 32'(io.rxd_sync), 32'h1);
            if (e == 3) check("rxled_e3", 32'(io.led[1]), 32'h0);
            if (e == 4) check("rxled_e4", 32'(io.led[1]), 32'h1);
            if (e == 8) check("rxled_e8", 32'(io.led[1]), 32'h1);
            if (e == 9) check("rxled_e9", 32'(io.led[1]), 32'h0);
        end

        // RX retrigger 3 cycles after the first edge
        for (int e = 1; e <= 14; e++) begin
            io.rxd_raw = (e == 1 || e == 4) ? 1'b0 : 1'b1;
            tick();
            if (e == 4)  check("rtrg_e4", 32'(io.led[1]), 32'h1);
            if (e == 9)  check("rtrg_e9", 32'(io.led[1]), 32'h1);
            if (e == 11) check("rtrg_e11", 32'(io.led[1]), 32'h1);
            if (e == 12) check("rtrg_e12", 32'(io.led[1]), 32'h0);
        end

        // TX path
        for (int e = 1; e <= 10; e++) begin
            io.core_txd = (e <= 2) ? 1'b0 : 1'b1;
            tick();
            if (e == 1) check("txd_e1", 32'(io.txd), 32'h0);
            if (e == 2) check("txd_e2", 32'(io.txd), 32'h0);
            if (e == 3) check("txd_e3", 32'(io.txd), 32'h1);
            if (e == 2) check("txled_e2", 32'(io.led[2]), 32'h0);
            if (e == 3) check("txled_e3", 32'(io.led[2]), 32'h1);
            if (e == 7) check("txled_e7", 32'(io.led[2]), 32'h1);
            if (e == 8) check("txled_e8", 32'(io.led[2]), 32'h0);
        end

        // mode select
        io.core_status = 4'b0101;
        io.led_mode    = 1'b1;
        tick();
        check("pass_0101", 32'(io.led), 32'h5);
        io.core_status = 4'b1010;
        tick();
        check("pass_1010", 32'(io.led), 32'ha);
        io.led_mode = 1'b0;
        tick();
        check("diag_hi", 32'(io.led[3:1]), 32'h4);

        // reset in the middle of hold, debounce and stretching
        for (int e = 1; e <= 8; e++) begin
            io.btn_n_raw = 1'b0;
            io.rxd_raw   = (e == 5) ? 1'b0 : 1'b1;
            io.core_txd  = (e >= 6) ? 1'b0 : 1'b1;
            tick();
        end
        check("pre_core_reset", 32'(io.core_reset), 32'h1);
        check("pre_act_leds", 32'(io.led[2:1]), 32'h3);
        reset        = 1'b1;
        io.btn_n_raw = 1'b1;
        io.rxd_raw   = 1'b1;
        tick();
        check("mid_core_reset", 32'(io.core_reset), 32'h1);
        check("mid_led", 32'(io.led), 32'h0);
        check("mid_txd", 32'(io.txd), 32'h1);
        check("mid_rxd_sync", 32'(io.rxd_sync), 32'h1);
        reset       = 1'b0;
        io.core_txd = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 3)  check("post_hold_e3", 32'(io.core_reset), 32'h1);
            if (e == 4)  check("post_fall_e4", 32'(io.core_reset), 32'h0);
            if (e == 4)  check("post_act_e4", 32'(io.led[2:1]), 32'h0);
            if (e == 10) check("post_hb_e10", 32'(io.led[0]), 32'h0);
            if (e == 11) check("post_hb_e11", 32'(io.led[0]), 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/arty_io_conditioner.md
# arty_io_conditioner

Parametrised board-level I/O conditioning block that sits between the Arty S7 pins and the `top_md5` core. It provides the following:
- synchronises the raw UART RX and reset-button pins;
- debounces the button and generates a stretched, synchronous core reset;
- registers the core TX line;
- drives a configurable LED bank: heartbeat, RX/TX activity, or core-status passthrough, selected by a mode input.

It replaces the bare pin-to-core wiring of the previous board top with measured, deterministic reset and status behaviour.

## Interface

Parameters:
- CLK_FREQUENCY, 100_000_000, clock frequency in Hz.
- HEARTBEAT_HZ, 1, heartbeat LED blink rate. Half-period is CLK_FREQUENCY/(2*HEARTBEAT_HZ) cycles, which must be ≥1.
- NUM_LEDS, 4, LED count. Must be ≥3.
- SYNC_STAGES, 2, synchroniser depth. Must be ≥2.
- DEBOUNCE_CYCLES, 1_000_000, number of cycles the button input must be stable before its debounced state changes. Must be ≥1.
- RST_HOLD_CYCLES, 16, number of cycles core_reset is held after reset and button are both released. Must be ≥1.
- ACT_STRETCH_CYCLES, 5_000_000, on-time of an activity LED per trigger. Must be ≥1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: **already decided** — synchronous, active-high block reset.
- btn_n_raw, input, 1: raw reset button. Active-low, asynchronous to clk.
- rxd_raw, input, 1: raw UART RX pin. Asynchronous to clk, idles high.
- core_txd, input, 1: UART TX from the core.
- core_status, input, NUM_LEDS: core status bits.
- led_mode, input, 1: LED mode select. 0 = diagnostic, 1 = passthrough.
- rxd_sync, output, 1: synchronised RX, for the core.
- txd, output, 1: registered TX, to the pin.
- core_reset, output, 1: synchronous active-high reset for the core.
- led, output, NUM_LEDS: LED drive.

## Operation

**Synchronisers**
- Two SYNC_STAGES-deep flop chains, one for btn_n_raw and one for rxd_raw.
- Every stage resets to 1.
- rxd_sync is the last stage of the rxd_raw chain.

**Debounce**
- pressed = ~(synchronised button).
- btn_db resets to 0. Its counter resets to 0.
- When pressed ≠ btn_db, the counter increments. When it reaches DEBOUNCE_CYCLES-1, btn_db ← pressed and the counter clears.
- When pressed = btn_db, the counter clears. Any glitch therefore restarts the count.

**Core reset**
- hold_cnt resets to RST_HOLD_CYCLES.
- While btn_db=1, hold_cnt reloads to RST_HOLD_CYCLES.
- Otherwise it decrements, saturating at 0.
- core_reset is registered and equals (hold_cnt≠0) from the previous cycle. Its reset value is 1.
- Pressing the button mid-hold reloads the count.

**TX**
- txd is a one-flop copy of core_txd. Reset value 1.

**Activity stretchers**
- RX stretcher:
  - Triggered by a falling edge on rxd_sync, detected against a registered previous value (reset value 1).
  - A trigger loads rx_cnt with ACT_STRETCH_CYCLES. Otherwise rx_cnt decrements, saturating at 0.
  - A retrigger while running reloads the count.
- TX stretcher: identical, but triggered by a falling edge on txd.
- Both counters reset to 0.
- Stretchers and the heartbeat are cleared only by reset. They keep running while core_reset is high.

**Heartbeat**
- A counter runs 0 … CLK_FREQUENCY/(2*HEARTBEAT_HZ)-1.
- On the terminal count it wraps to 0 and hb toggles.
- hb and the counter reset to 0.

**LED mux**
- led is registered. Reset value all-zeros.
- led_mode=0 (diagnostic):
  - led[0]=hb
  - led[1]=(rx_cnt≠0)
  - led[2]=(tx_cnt≠0)
  - led[NUM_LEDS-1:3]=core_status[NUM_LEDS-1:3]
- led_mode=1 (passthrough): led=core_status.
- led_mode is sampled every cycle and takes effect on the next led update.

**Widths**
- Each counter is $clog2(max+1) bits for its maximum value.
- No counter wraps except the heartbeat counter.

## Timing

- **Reset:** reset sampled high forces all of the following on that edge, including when it arrives mid-hold or mid-debounce:
  - core_reset=1
  - txd=1
  - rxd_sync=1
  - led=0
  - all counters to their reset values
- **rxd_sync latency:** SYNC_STAGES cycles from rxd_raw.
- **txd latency:** 1 cycle from core_txd.
- **led[1] on RX falling edge:** call the edge that first samples rxd_raw low E0. led[1] rises after edge E0+SYNC_STAGES+1 and stays high for exactly ACT_STRETCH_CYCLES cycles if not retriggered.
- **led[2] on core_txd falling edge:** rises 3 edges after core_txd is first sampled low.
- **Button press, debounced:** btn_db=1 is reached SYNC_STAGES+DEBOUNCE_CYCLES edges after btn_n_raw is first sampled low (counting that first sampling edge as edge 1).
- **Core reset release:** the first edge at which reset is sampled low with btn_db=0 starts the hold. core_reset falls after exactly RST_HOLD_CYCLES+1 edges from that point.
- **Mode change:** led reflects a new led_mode 1 cycle later.

## Test plan

All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=3, ACT_STRETCH_CYCLES=5, CLK_FREQUENCY=20, HEARTBEAT_HZ=1, NUM_LEDS=4.

1. **Reset and heartbeat.** Hold reset for 2 cycles, then release.
   - While reset is held: led=0, txd=1, core_reset=1.
   - After release: core_reset falls 4 edges later.
   - led[0] toggles every 10 cycles.
2. **Button glitch and valid press.** Drive btn_n_raw low for 3 cycles, then high.
   - The 3-cycle glitch leaves core_reset low.
   - Then drive it low for 10 cycles: core_reset rises 7 edges after the first low sample.
   - core_reset falls 4 edges after btn_db clears.
3. **RX activity.** Drive a single rxd_raw low pulse.
   - rxd_sync follows with 2-cycle latency.
   - led[1] rises at E0+3 and stays high for 5 cycles.
   - A second falling edge 3 cycles in extends led[1] to 5 cycles after the retrigger.
4. **TX path.** Toggle core_txd 1→0→1.
   - txd mirrors core_txd 1 cycle later.
   - led[2] is high for 5 cycles.
5. **Mode select.** Drive core_status=4'b1010.
   - led_mode=1: led=4'b1010 one cycle later.
   - led_mode=0: led[3]=1 and led[2:0] show the diagnostic signals.
6. **Reset mid-operation.** Assert reset during the core_reset hold, during the debounce count, and while the stretchers are active.
   - All counters and outputs return to their reset values on that edge.
